// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce / bounce-stimulus blocks.
// Holds the FSM state encoding, the LFSR tap mask and its default seed.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TOGGLE,
        ST_REVERT,
        ST_SETTLE
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Galois step: shift right and fold the taps back in when a one drops out
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reseeds on reset and steps every cycle.
module lfsr16
    import debounce_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bounce_emulator.sv
// Contact-bounce emulator: chatters bounce_out between old and new levels for
// LFSR-chosen phase lengths, holds the target for SETTLE cycles, then pulses done.
module bounce_emulator
    import debounce_pkg::*;
#(
    parameter logic        INIT_LEVEL = 1'b0,
    parameter int          BOUNCES    = 3,
    parameter int          PULSE_W    = 4,
    parameter int          SETTLE     = 16,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cmd_valid,
    input  logic cmd_level,
    output logic cmd_ready,
    output logic bounce_out,
    output logic settled,
    output logic done
);

    localparam int PW = PULSE_W + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("bounce_emulator: LFSR_SEED must be nonzero");
    end
    if (PULSE_W < 1 || PULSE_W > 8) begin : g_bad_pulse_w
        $error("bounce_emulator: PULSE_W must be 1..8");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("bounce_emulator: SETTLE must be at least 1");
    end
    if (BOUNCES < 0 || BOUNCES > 15) begin : g_bad_bounces
        $error("bounce_emulator: BOUNCES must be 0..15");
    end

    logic [15:0]   lfsr;
    state_t        state;
    logic          target;
    logic          old;
    logic [PW-1:0] phase_cnt;
    logic [3:0]    bounce_cnt;
    logic [SW-1:0] settle_cnt;
    logic [PW-1:0] len;
    logic          unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (lfsr)
    );

    // Phase length 1..2^PULSE_W; the extra counter bit keeps the +1 from wrapping
    assign len         = PW'(lfsr[PULSE_W-1:0]) + PW'(1);
    assign unused_lfsr = ^lfsr;

    assign cmd_ready = (state == ST_IDLE);
    assign settled   = (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bounce_out <= INIT_LEVEL;
            done       <= 1'b0;
            target     <= INIT_LEVEL;
            old        <= INIT_LEVEL;
            phase_cnt  <= '0;
            bounce_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target     <= cmd_level;
                        old        <= bounce_out;
                        bounce_out <= cmd_level;
                        bounce_cnt <= '0;
                        if (cmd_level != bounce_out && BOUNCES > 0) begin
                            state     <= ST_TOGGLE;
                            phase_cnt <= len;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                ST_TOGGLE: begin
                    if (phase_cnt == PW'(1)) begin
                        state      <= ST_REVERT;
                        phase_cnt  <= len;
                        bounce_out <= old;
                    end else begin
                        phase_cnt <= phase_cnt - PW'(1);
                    end
                end
                ST_REVERT: begin
                    if (phase_cnt == PW'(1)) begin
                        bounce_cnt <= bounce_cnt + 4'd1;
                        bounce_out <= target;
                        if (bounce_cnt + 4'd1 == 4'(BOUNCES)) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state     <= ST_TOGGLE;
                            phase_cnt <= len;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: default build plus a BOUNCES=0/SETTLE=1 build.
module tb_bounce_emulator;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_level = 1'b0;
    logic cmd_ready, bounce_out, settled, done;

    logic v0 = 1'b0;
    logic l0 = 1'b0;
    logic ready0, out0, settled0, done0;

    logic [15:0] m;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bounce_emulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_level  (cmd_level),
        .cmd_ready  (cmd_ready),
        .bounce_out (bounce_out),
        .settled    (settled),
        .done       (done)
    );

    bounce_emulator #(.BOUNCES(0), .SETTLE(1)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (v0),
        .cmd_level  (l0),
        .cmd_ready  (ready0),
        .bounce_out (out0),
        .settled    (settled0),
        .done       (done0)
    );

    // Reference LFSR: 16-bit Galois, taps B400, seeded by reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= 16'hACE1;
        else          m <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller has cmd_valid/cmd_level set for acceptance on the next edge.
    task automatic run_bounce(input logic tgt, input logic old, input bit noise);
        int len;
        int nlen;
        chk("accept_ready", cmd_ready, 1'b1);
        len  = int'(m[3:0]) + 1;
        nlen = len;
        step();
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < len; i++) begin
                if (noise) begin
                    cmd_valid = 1'b1;
                    cmd_level = ~cmd_level;
                end else begin
                    cmd_valid = 1'b0;
                end
                chk($sformatf("phase%0d_out", ph), bounce_out, (ph % 2 == 0) ? tgt : old);
                chk("busy_ready", cmd_ready, 1'b0);
                chk("busy_done", done, 1'b0);
                if (i == len - 1) nlen = int'(m[3:0]) + 1;
                step();
            end
            len = nlen;
        end
        for (int i = 0; i < 16; i++) begin
            if (noise) begin
                cmd_valid = 1'b1;
                cmd_level = ~cmd_level;
            end
            chk("settle_out", bounce_out, tgt);
            chk("settle_settled", settled, 1'b0);
            chk("settle_done", done, 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        chk("end_done", done, 1'b1);
        chk("end_ready", cmd_ready, 1'b1);
        chk("end_settled", settled, 1'b1);
        chk("end_out", bounce_out, tgt);
    endtask

    initial begin
        int len;
        #3 reset_n = 1'b0;
        step();
        step();
        chk("rst_out", bounce_out, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_settled", settled, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst0_out", out0, 1'b0);
        reset_n = 1'b1;
        chk16("rst_lfsr", dut.lfsr, 16'hACE1);

        // Rising command with chatter; first phase is ACE1[3:0]+1 = 2 cycles
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        run_bounce(1'b1, 1'b0, 1'b0);

        // Back-to-back falling command accepted in the done cycle, noise on inputs
        cmd_valid = 1'b1;
        cmd_level = 1'b0;
        run_bounce(1'b0, 1'b1, 1'b1);
        step();
        chk("done_one_cycle", done, 1'b0);

        // Same-level command: no chatter, done SETTLE cycles later
        cmd_valid = 1'b1;
        cmd_level = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("same_out", bounce_out, 1'b0);
            chk("same_ready", cmd_ready, 1'b0);
            chk("same_done", done, 1'b0);
            step();
        end
        chk("same_end_done", done, 1'b1);
        chk("same_end_out", bounce_out, 1'b0);
        step();

        // Reset asserted while in REVERT
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        len = int'(m[3:0]) + 1;
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_toggle", bounce_out, 1'b1);
        for (int i = 0; i < len; i++) step();
        chk("pre_rst_revert", bounce_out, 1'b0);
        chk("pre_rst_busy", settled, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_ready", cmd_ready, 1'b1);
        chk("async_settled", settled, 1'b1);
        chk("async_out", bounce_out, 1'b0);
        chk("async_done", done, 1'b0);
        chk16("async_lfsr", dut.lfsr, 16'hACE1);
        step();
        chk("rst_no_done", done, 1'b0);
        reset_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        run_bounce(1'b1, 1'b0, 1'b0);

        // BOUNCES=0, SETTLE=1 build
        v0 = 1'b1;
        l0 = 1'b1;
        chk("b0_idle_out", out0, 1'b0);
        step();
        v0 = 1'b0;
        chk("b0_t1_out", out0, 1'b1);
        chk("b0_t1_ready", ready0, 1'b0);
        chk("b0_t1_done", done0, 1'b0);
        step();
        chk("b0_t2_done", done0, 1'b1);
        chk("b0_t2_out", out0, 1'b1);
        chk("b0_t2_ready", ready0, 1'b1);
        chk("b0_t2_settled", settled0, 1'b1);
        step();
        chk("b0_t3_done", done0, 1'b0);
        chk("b0_t3_out", out0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Contact-bounce emulator: the transmit-side counterpart of the debouncer. It accepts a clean target level on a valid/ready command interface. It drives a single-bit output that chatters between the old and new levels for a pseudo-random number of cycles, then settles. It sits in the test and demo path, feeding a debouncer input from an on-chip stimulus source instead of a mechanical switch.

## Interface
- INIT_LEVEL, 1'b0: value of bounce_out after reset.
- BOUNCES, 3: number of chatter pairs (toggle plus revert) before settling; 0 to 15 allowed.
- PULSE_W, 4: width of the random pulse-length field; each chatter phase lasts 1 to 2^PULSE_W cycles; 1 to 8 allowed.
- SETTLE, 16: cycles bounce_out holds the target before completion; must be at least 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, input, 1: sole clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command present.
- cmd_level, input, 1: target level; sampled on acceptance.
- cmd_ready, output, 1: high only in IDLE.
- bounce_out, output, 1: emulated contact signal; registered.
- settled, output, 1: high only in IDLE (bounce_out is stable).
- done, output, 1: one-cycle completion pulse; registered.

## Operation
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both high. The target and the old level (current bounce_out) are latched.
- States are IDLE, TOGGLE, REVERT and SETTLE.
- IDLE:
  - On acceptance with target equal to old: go to SETTLE without toggling.
  - On acceptance with target not equal to old and BOUNCES > 0: go to TOGGLE.
  - On acceptance with target not equal to old and BOUNCES = 0: go to SETTLE, driving the target.
- TOGGLE: bounce_out equals target for len cycles, then go to REVERT.
- REVERT: bounce_out equals old for len cycles. Increment the bounce count. If the count equals BOUNCES, go to SETTLE; otherwise go to TOGGLE.
- SETTLE: bounce_out equals target for SETTLE cycles, then go to IDLE with done high.
- Pulse length: len = lfsr[PULSE_W-1:0] + 1, captured into the phase counter on entry to each TOGGLE or REVERT phase. The counter is PULSE_W+1 bits wide; len is never 0.
- LFSR:
  - 16-bit Galois, tap mask 16'hB400.
  - Free-running: advances every cycle from reset, independent of state.
- Counter widths:
  - Bounce counter is 4 bits.
  - Settle counter is $clog2(SETTLE+1) bits.
  - Neither counter wraps; each is cleared on entry to its state.
- cmd_valid and cmd_level are ignored outside IDLE; no queuing.
- Elaboration fails on illegal parameters (LFSR_SEED = 0, PULSE_W out of range, SETTLE = 0, BOUNCES > 15).

## Timing
- Reset values:
  - bounce_out is INIT_LEVEL.
  - done is 0.
  - State is IDLE, so cmd_ready and settled are 1.
  - LFSR is LFSR_SEED; all counters are 0.
- Acceptance at edge T: from T+1, bounce_out is the target (TOGGLE or SETTLE), and cmd_ready and settled are low.
- Each phase lasts exactly its len cycles; phase changes are edge-aligned with no gap cycles.
- Total busy time is the sum of all 2×BOUNCES lens plus SETTLE cycles.
- done is high for exactly one cycle: the first IDLE cycle, coincident with cmd_ready rising. A new command may be accepted in that same cycle.
- Same-level command: busy for exactly SETTLE cycles, bounce_out unchanged, then done.
- reset_n low mid-operation:
  - Outputs and state go immediately (asynchronously) to reset values; no done pulse.
  - The LFSR is reseeded.
  - Release is synchronous to clk.

## Structure
- Shared package debounce_pkg holds:
  - the state enum (IDLE, TOGGLE, REVERT, SETTLE);
  - LFSR_TAPS = 16'hB400;
  - the default LFSR_SEED.
- Sub-module lfsr16:
  - Inputs: clk, reset_n, SEED.
  - Output: 16-bit state.
  - Also reused by future stimulus blocks.
- The FSM, phase counter, bounce counter and settle counter live in bounce_emulator.

## Test plan
- Reset with INIT_LEVEL=0 -> bounce_out=0, cmd_ready=1, settled=1, done=0; LFSR equals 16'hACE1 on the first post-reset cycle.
- Defaults, cmd_level=1 accepted -> exactly 3 high/low chatter pairs. Each phase length is between 1 and 16 cycles and matches a reference LFSR model. Then 16 cycles high, then a single done pulse with cmd_ready=1.
- cmd_level equal to the current level -> bounce_out never toggles; done exactly 16 cycles after acceptance.
- BOUNCES=0, SETTLE=1, command 0->1 -> bounce_out=1 at T+1; done at T+2; no low glitch.
- cmd_valid held high with alternating cmd_level during busy -> ignored. A new command is accepted in the done cycle; back-to-back transitions are correct.
- reset_n asserted during REVERT -> same-cycle return to INIT_LEVEL and IDLE, no done pulse; the next command behaves as after a fresh reset.
